alu_control: RTL and testbench
==============================

Name: alu_control

Overview:
- Registered ALU-control decoder for the single-cycle/pipelined MIPS datapath.
- Maps the main-control `alu_op` field and the R-type funct field (`instruction[5:0]`) to a 4-bit ALU operation code consumed by the ALU.
- Output is registered: one clock of latency, cleared by an asynchronous active-low reset.

Parameters:
- None. All encodings below are fixed.

Ports:
- `clk`  input  1  system clock; the output register updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset. 0 = in reset, 1 = run.
- `alu_op`  input  2  ALU operation class from main control.
- `instruction_5_0`  input  6  funct field of the current instruction.
- `alu_out`  output  4  ALU operation code, registered.

Behaviour:
- Interface: one clock `clk`. `reset` is asynchronous and active-low.
- Reset:
  - While `reset`=0, `alu_out` is forced to 4'b0000 immediately, without waiting for a clock edge.
  - It stays 4'b0000 for as long as `reset` is held low, whatever the other inputs do.
- Decode (combinational next-value `code`):
  - `alu_op`=2'b00 → 4'b0010 (add; lw/sw/addi). Funct is ignored.
  - `alu_op`=2'b01 → 4'b0110 (sub; beq). Funct is ignored.
  - `alu_op`=2'b10 (R-type) → decoded from funct:
    - 100000 → 0010 (add)
    - 100010 → 0110 (sub)
    - 100100 → 0000 (and)
    - 100101 → 0001 (or)
    - 100111 → 1100 (nor)
    - 101010 → 0111 (slt)
    - 101111 → 1101 (not)
    - any other funct → 1111 (invalid; the ALU treats it as a no-op)
  - `alu_op`=2'b11 → 1111 (invalid). Funct is ignored.
- Register:
  - On each rising `clk` edge with `reset`=1, `alu_out` <= `code`.
  - Latency is exactly one cycle from a stable input to `alu_out`.
  - Inputs are sampled only at the edge; glitches between edges have no effect.
- Reset release: the first rising edge with `reset`=1 loads the decode of the inputs present at that edge.
- Reset mid-operation: asserting `reset` low at any time clears `alu_out` to 0000 asynchronously. Decoding resumes on the next rising edge after release.
- X/Z on inputs: not handled specially; the bench never drives X/Z after reset release.
- No handshake and no internal state beyond the 4-bit output register.

Test Plan:
- Reset hold: drive `reset`=0 with `alu_op`=10, funct=100010 and toggle `clk` for 5 cycles → `alu_out`=0000 throughout. Then set `reset`=1 → after the next rising edge `alu_out`=0110.
- Non-R classes: `alu_op`=00, funct=010101 → 0010 one edge later. `alu_op`=01, same funct → 0110. `alu_op`=00 again → 0010. `alu_op`=11 → 1111.
- R-type sweep (`alu_op`=10), checking each result one edge after the input changes:
  - funct 100000 → 0010
  - 100010 → 0110
  - 100100 → 0000
  - 100101 → 0001
  - 100111 → 1100
  - 101010 → 0111
  - 101111 → 1101
- Unknown funct: `alu_op`=10, funct=000000 and funct=111111 → 1111.
- Latency: change the inputs 2 ns after a rising edge. `alu_out` must hold its old value until the next rising edge, then show the new code.
- Asynchronous reset mid-run: while `alu_out`=1100, pull `reset` low between edges → `alu_out`=0000 before the next edge. Release it → the correct decode appears at the following edge.

Source files
------------

// File: rtl/alu_control.sv
// rtl/alu_control.sv - registered MIPS ALU-control decoder (alu_op + funct -> 4-bit ALU code)
module alu_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] alu_op,
  input  logic [5:0] instruction_5_0,
  output logic [3:0] alu_out
);

  localparam logic [3:0] CODE_AND     = 4'b0000;
  localparam logic [3:0] CODE_OR      = 4'b0001;
  localparam logic [3:0] CODE_ADD     = 4'b0010;
  localparam logic [3:0] CODE_SUB     = 4'b0110;
  localparam logic [3:0] CODE_SLT     = 4'b0111;
  localparam logic [3:0] CODE_NOR     = 4'b1100;
  localparam logic [3:0] CODE_NOT     = 4'b1101;
  localparam logic [3:0] CODE_INVALID = 4'b1111;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOT = 6'b101111;

  logic [3:0] code;

  // Unrecognised classes and functs decode to the invalid code, which the ALU treats as a no-op.
  always_comb begin
    code = CODE_INVALID;
    unique case (alu_op)
      2'b00: code = CODE_ADD;
      2'b01: code = CODE_SUB;
      2'b10: begin
        case (instruction_5_0)
          FUNCT_ADD: code = CODE_ADD;
          FUNCT_SUB: code = CODE_SUB;
          FUNCT_AND: code = CODE_AND;
          FUNCT_OR:  code = CODE_OR;
          FUNCT_NOR: code = CODE_NOR;
          FUNCT_SLT: code = CODE_SLT;
          FUNCT_NOT: code = CODE_NOT;
          default:   code = CODE_INVALID;
        endcase
      end
      2'b11: code = CODE_INVALID;
      default: code = CODE_INVALID;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out <= 4'b0000;
    end else begin
      alu_out <= code;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// tb/tb_alu_control.sv - directed self-checking bench for alu_control
module tb_alu_control;

  logic       clk;
  logic       reset;
  logic [1:0] alu_op;
  logic [5:0] instruction_5_0;
  logic [3:0] alu_out;

  int errors = 0;
  int checks = 0;

  alu_control dut (
    .clk             (clk),
    .reset           (reset),
    .alu_op          (alu_op),
    .instruction_5_0 (instruction_5_0),
    .alu_out         (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] expected);
    checks++;
    assert (alu_out === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, alu_out, expected);
    end
  endtask

  // Drive inputs just after an edge, then check one rising edge later.
  task automatic apply(input string tag, input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] expected);
    alu_op          = op;
    instruction_5_0 = funct;
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  initial begin
    reset           = 1'b0;
    alu_op          = 2'b10;
    instruction_5_0 = 6'b100010;
    #1;
    check("reset_initial", 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold_%0d", i), 4'b0000);
    end

    reset = 1'b1;
    @(posedge clk);
    #1;
    check("release_sub", 4'b0110);

    apply("class00_add", 2'b00, 6'b010101, 4'b0010);
    apply("class01_sub", 2'b01, 6'b010101, 4'b0110);
    apply("class00_again", 2'b00, 6'b010101, 4'b0010);
    apply("class11_inv", 2'b11, 6'b010101, 4'b1111);

    apply("r_add", 2'b10, 6'b100000, 4'b0010);
    apply("r_sub", 2'b10, 6'b100010, 4'b0110);
    apply("r_and", 2'b10, 6'b100100, 4'b0000);
    apply("r_or",  2'b10, 6'b100101, 4'b0001);
    apply("r_nor", 2'b10, 6'b100111, 4'b1100);
    apply("r_slt", 2'b10, 6'b101010, 4'b0111);
    apply("r_not", 2'b10, 6'b101111, 4'b1101);
    apply("r_unk_000000", 2'b10, 6'b000000, 4'b1111);
    apply("r_unk_111111", 2'b10, 6'b111111, 4'b1111);
    apply("class11_r_funct", 2'b11, 6'b100000, 4'b1111);

    // Latency: inputs change 2 ns after an edge; output must hold until the next edge.
    apply("lat_setup_or", 2'b10, 6'b100101, 4'b0001);
    #1;
    alu_op          = 2'b10;
    instruction_5_0 = 6'b101010;
    #1;
    check("lat_hold_old", 4'b0001);
    @(posedge clk);
    #1;
    check("lat_new_slt", 4'b0111);

    // Glitch between edges that is reverted before the edge has no effect.
    #2;
    instruction_5_0 = 6'b100100;
    #2;
    instruction_5_0 = 6'b101010;
    @(posedge clk);
    #1;
    check("glitch_ignored", 4'b0111);

    // Asynchronous reset mid-run.
    apply("async_setup_nor", 2'b10, 6'b100111, 4'b1100);
    #2;
    reset = 1'b0;
    #1;
    check("async_clear", 4'b0000);
    alu_op = 2'b00;
    @(posedge clk);
    #1;
    check("async_held_low", 4'b0000);
    alu_op = 2'b10;
    reset  = 1'b1;
    #1;
    check("async_release_wait", 4'b0000);
    @(posedge clk);
    #1;
    check("async_resume_nor", 4'b1100);
    apply("after_resume_and", 2'b10, 6'b100100, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
